// File: rtl/joypad_controller_if.sv
// ---------------------------------------------------------------------------
// joypad_controller_if
//
// CPU-side memory-mapped bus seen by the joypad block.
//   cs    : chip select for the joypad address range (memory controller)
//   rd_n  : active-low read strobe
//   wr_n  : active-low write strobe
//   A     : 16-bit address
//   Di    : write data from the CPU
//   Do    : read data back to the memory controller's read mux
//
// master : CPU / memory-controller side
// slave  : joypad_controller side
// ---------------------------------------------------------------------------
interface joypad_controller_if;
   logic        cs;
   logic        rd_n;
   logic        wr_n;
   logic [15:0] A;
   logic [7:0]  Di;
   logic [7:0]  Do;

   modport master (output cs, rd_n, wr_n, A, Di, input Do);
   modport slave  (input cs, rd_n, wr_n, A, Di, output Do);
endinterface

// File: rtl/joypad_controller.sv
// ---------------------------------------------------------------------------
// joypad_controller
//
// P1 joypad register at 0xFF00. Scans a 2x4 active-low button matrix one row
// at a time, debounces all eight buttons, exposes the selected rows through
// P1[3:0] and raises a level interrupt request on any falling P1 input line.
//
// Ports
//   clock       : system clock, rising edge
//   reset       : synchronous, active-high
//   bus         : CPU bus (cs, rd_n, wr_n, A, Di, Do), slave side
//   joypad_data : matrix column inputs, active-low (0 = pressed)
//   joypad_sel  : matrix row selects, active-low; bit 0 directions,
//                 bit 1 buttons
//   int_req     : joypad interrupt request, level
//   int_ack     : single-cycle acknowledge from the interrupt controller
//
// Button order within a row (bit 3..0):
//   directions : Down, Up, Left, Right
//   buttons    : Start, Select, B, A
// ---------------------------------------------------------------------------
module joypad_controller #(
   parameter int SETTLE_CYCLES    = 16,
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   joypad_controller_if.slave        bus,
   input  logic [3:0]                joypad_data,
   output logic [1:0]                joypad_sel,
   output logic                      int_req,
   input  logic                      int_ack
);

   localparam logic [15:0] P1_ADDR = 16'hFF00;
   localparam int          SCW     = $clog2(SETTLE_CYCLES + 1);
   localparam int          DCW     = $clog2(DEBOUNCE_SAMPLES + 1);

   typedef enum logic [1:0] {
      DIR_SETTLE,
      DIR_SAMPLE,
      BTN_SETTLE,
      BTN_SAMPLE
   } scan_state_t;

   scan_state_t    state;
   scan_state_t    state_next;
   logic [SCW-1:0] settle_cnt;
   logic           settle_done;
   logic           dir_sample;
   logic           btn_sample;

   // -------------------------------------------------------------------------
   // Scan FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state is always written with <= so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) state <= DIR_SETTLE;
      else       state <= state_next;
   end

   assign settle_done = ((state == DIR_SETTLE) || (state == BTN_SETTLE)) &&
                        (settle_cnt == SCW'(SETTLE_CYCLES - 1));

   // Counts the cycles spent in a SETTLE state; idles at 0 through SAMPLE.
   always_ff @(posedge clock) begin
      if (reset || settle_done || dir_sample || btn_sample) settle_cnt <= '0;
      else                                                  settle_cnt <= settle_cnt + 1'b1;
   end

   // -------------------------------------------------------------------------
   // Scan FSM: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         DIR_SETTLE: if (settle_done) state_next = DIR_SAMPLE;
         DIR_SAMPLE:                  state_next = BTN_SETTLE;
         BTN_SETTLE: if (settle_done) state_next = BTN_SAMPLE;
         BTN_SAMPLE:                  state_next = DIR_SETTLE;
         default:                     state_next = DIR_SETTLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Scan FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      joypad_sel = 2'b11;
      dir_sample = 1'b0;
      btn_sample = 1'b0;
      case (state)
         DIR_SETTLE: joypad_sel = 2'b10;
         DIR_SAMPLE: begin
            joypad_sel = 2'b10;
            dir_sample = 1'b1;
         end
         BTN_SETTLE: joypad_sel = 2'b01;
         BTN_SAMPLE: begin
            joypad_sel = 2'b01;
            btn_sample = 1'b1;
         end
         default:    joypad_sel = 2'b11;
      endcase
      // Both rows deselected while held in reset; no sampling either.
      if (reset) begin
         joypad_sel = 2'b11;
         dir_sample = 1'b0;
         btn_sample = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Debouncers: bits 3:0 directions, bits 7:4 buttons
   // -------------------------------------------------------------------------
   logic [7:0]     stable;
   logic [7:0]     stable_next;
   logic [DCW-1:0] match_cnt      [8];
   logic [DCW-1:0] match_cnt_next [8];
   logic [7:0]     sample_vec;
   logic [7:0]     row_en;

   // The same column bus carries whichever row is selected.
   assign sample_vec = {joypad_data, joypad_data};
   assign row_en     = {{4{btn_sample}}, {4{dir_sample}}};

   always_comb begin
      stable_next    = stable;
      match_cnt_next = match_cnt;
      for (int i = 0; i < 8; i++) begin
         if (row_en[i]) begin
            if (sample_vec[i] == stable[i]) begin
               match_cnt_next[i] = '0;
            end else if (match_cnt[i] == DCW'(DEBOUNCE_SAMPLES - 1)) begin
               // This is the DEBOUNCE_SAMPLES-th differing sample in a row.
               stable_next[i]    = sample_vec[i];
               match_cnt_next[i] = '0;
            end else begin
               match_cnt_next[i] = match_cnt[i] + 1'b1;
            end
         end
      end
   end

   // NOTE: the counters are a small flop array, not a RAM, so they can and
   // must take reset; a reset mid-debounce has to discard partial progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         stable <= '1;
         for (int i = 0; i < 8; i++) match_cnt[i] <= '0;
      end else begin
         stable    <= stable_next;
         match_cnt <= match_cnt_next;
      end
   end

   // -------------------------------------------------------------------------
   // P1 register and bus
   // -------------------------------------------------------------------------
   logic [1:0] psel;
   logic [3:0] p1_low;
   logic [7:0] p1_value;
   logic       p1_addr_hit;
   logic       p1_write;
   logic       p1_read;
   logic       unused_di;

   assign p1_addr_hit = (bus.A == P1_ADDR);
   assign p1_write    = bus.cs && !bus.wr_n && p1_addr_hit;
   assign p1_read     = bus.cs && !bus.rd_n && p1_addr_hit;

   // A psel bit of 1 deselects its row, forcing those lines to read released.
   assign p1_low   = (psel[0] ? 4'hF : stable[3:0]) & (psel[1] ? 4'hF : stable[7:4]);
   assign p1_value = {2'b11, psel, p1_low};

   // Any address other than P1, or no read strobe, returns all ones.
   assign bus.Do = p1_read ? p1_value : 8'hFF;

   // Only Di[5:4] are writable.
   assign unused_di = &{1'b0, bus.Di[7:6], bus.Di[3:0]};

   always_ff @(posedge clock) begin
      if (reset)         psel <= 2'b11;
      else if (p1_write) psel <= bus.Di[5:4];
   end

   // -------------------------------------------------------------------------
   // Interrupt: any P1 input line going 1 -> 0, including edges caused by a
   // psel change exposing an already-pressed button.
   // -------------------------------------------------------------------------
   logic [3:0] p1_prev;
   logic       p1_fall;

   assign p1_fall = |(p1_prev & ~p1_low);

   always_ff @(posedge clock) begin
      if (reset) begin
         p1_prev <= 4'hF;
         int_req <= 1'b0;
      end else begin
         p1_prev <= p1_low;
         // A new edge wins over a simultaneous acknowledge.
         if (p1_fall)      int_req <= 1'b1;
         else if (int_ack) int_req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_joypad_controller.sv
// ---------------------------------------------------------------------------
// tb_joypad_controller
//
// Directed scenarios followed by a randomized phase. A cycle-level reference
// model (scan schedule from a cycle index, per-button integer debounce
// counters driven by which buttons are physically pressed, P1/interrupt
// rules) predicts joypad_sel, int_req and Do every cycle.
// ---------------------------------------------------------------------------
module tb_joypad_controller;

   localparam int S   = 16;
   localparam int D   = 4;
   localparam int PER = 2 * (S + 1);

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] joypad_data;
   logic [1:0] joypad_sel;
   logic       int_req;
   logic       int_ack;

   // Physical button state: bit 0..3 Right, Left, Up, Down; bit 4..7 A, B,
   // Select, Start. 1 = pressed.
   logic [7:0] pressed;

   joypad_controller_if bus ();

   joypad_controller #(
      .SETTLE_CYCLES    (S),
      .DEBOUNCE_SAMPLES (D)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .joypad_data (joypad_data),
      .joypad_sel  (joypad_sel),
      .int_req     (int_req),
      .int_ack     (int_ack)
   );

   always #5 clock = ~clock;

   // The button matrix: a selected (low) row pulls pressed columns low.
   always_comb begin
      joypad_data = 4'hF;
      if (joypad_sel == 2'b10)      joypad_data = ~pressed[3:0];
      else if (joypad_sel == 2'b01) joypad_data = ~pressed[7:4];
   end

   int tests = 0;
   int fails = 0;

   // ---------------- reference model ----------------
   int         m_t;
   int         m_btn_samples = 0;
   logic [7:0] m_stable;
   int         m_cnt [8];
   logic [1:0] m_psel;
   logic [3:0] m_prev;
   logic       m_int;

   function automatic logic [3:0] m_p1();
      logic [3:0] d;
      logic [3:0] b;
      d = m_psel[0] ? 4'hF : m_stable[3:0];
      b = m_psel[1] ? 4'hF : m_stable[7:4];
      return d & b;
   endfunction

   function automatic logic [1:0] exp_sel();
      if (reset) return 2'b11;
      return ((m_t % PER) <= S) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [7:0] exp_do();
      if (bus.cs && !bus.rd_n && bus.A == 16'hFF00) return {2'b11, m_psel, m_p1()};
      return 8'hFF;
   endfunction

   task automatic debounce(input int i);
      logic s;
      s = pressed[i] ? 1'b0 : 1'b1;
      if (s == m_stable[i]) begin
         m_cnt[i] = 0;
      end else begin
         m_cnt[i]++;
         if (m_cnt[i] == D) begin
            m_stable[i] = s;
            m_cnt[i]    = 0;
         end
      end
   endtask

   // Advances the model across one rising edge using this cycle's inputs.
   task automatic model_step();
      int         ph;
      logic [3:0] p1;
      if (reset) begin
         m_t      = 0;
         m_stable = 8'hFF;
         for (int i = 0; i < 8; i++) m_cnt[i] = 0;
         m_psel   = 2'b11;
         m_prev   = 4'hF;
         m_int    = 1'b0;
         return;
      end
      ph = m_t % PER;
      p1 = m_p1();
      if (|(m_prev & ~p1)) m_int = 1'b1;
      else if (int_ack)    m_int = 1'b0;
      m_prev = p1;
      if (bus.cs && !bus.wr_n && bus.A == 16'hFF00) m_psel = bus.Di[5:4];
      if (ph == S) begin
         for (int i = 0; i < 4; i++) debounce(i);
      end
      if (ph == 2 * S + 1) begin
         for (int i = 4; i < 8; i++) debounce(i);
         m_btn_samples++;
      end
      m_t++;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      #1;
      chk("joypad_sel", {6'b0, joypad_sel}, {6'b0, exp_sel()});
      chk("int_req",    {7'b0, int_req},    {7'b0, m_int});
      chk("do",         bus.Do,             exp_do());
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic bus_idle();
      bus.cs   = 1'b0;
      bus.rd_n = 1'b1;
      bus.wr_n = 1'b1;
      bus.A    = 16'h0000;
      bus.Di   = 8'h00;
   endtask

   task automatic write_p1(input logic [7:0] d);
      bus.cs   = 1'b1;
      bus.wr_n = 1'b0;
      bus.A    = 16'hFF00;
      bus.Di   = d;
      tick();
      bus_idle();
   endtask

   task automatic read_chk(input string tag, input logic [7:0] exp);
      bus.cs   = 1'b1;
      bus.rd_n = 1'b0;
      bus.A    = 16'hFF00;
      #1;
      chk(tag, bus.Do, exp);
      bus_idle();
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic wait_btn_samples(input int n);
      int start;
      int guard;
      start = m_btn_samples;
      guard = 0;
      while ((m_btn_samples - start) < n && guard < 200) begin
         tick();
         guard++;
      end
      chk("btn_sample_timeout", {7'b0, guard < 200}, 8'h01);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic found;
      int   guard;
      int   r;

      reset   = 1'b1;
      int_ack = 1'b0;
      pressed = 8'h00;
      bus_idle();
      model_step();
      @(posedge clock);
      #1;

      // Reset held for three cycles.
      run(3);
      chk("rst_sel", {6'b0, joypad_sel}, 8'h03);
      chk("rst_int", {7'b0, int_req},    8'h00);
      reset = 1'b0;

      // One full scan period after release.
      for (int c = 0; c < PER; c++) begin
         #1;
         chk("scan_sel", {6'b0, joypad_sel}, (c <= S) ? 8'h02 : 8'h01);
         tick();
      end
      read_chk("rst_read", 8'hFF);

      // Direction press: Right held.
      write_p1(8'h20);
      pressed = 8'h01;
      run(5 * PER);
      read_chk("dir_press", 8'hEE);
      chk("dir_int", {7'b0, int_req}, 8'h01);
      ack();
      chk("dir_ack", {7'b0, int_req}, 8'h00);

      // Bounce rejection: Right toggles every direction sample.
      pressed = 8'h00;
      run(5 * PER);
      read_chk("release_read", 8'hEF);
      for (int k = 0; k < 20; k++) begin
         pressed = (k % 2 == 0) ? 8'h01 : 8'h00;
         run(PER);
         read_chk("bounce_read", 8'hEF);
         chk("bounce_int", {7'b0, int_req}, 8'h00);
      end
      pressed = 8'h00;
      run(PER);

      // Interrupt handshake on button A.
      write_p1(8'h10);
      pressed  = 8'h10;
      bus.cs   = 1'b1;
      bus.rd_n = 1'b0;
      bus.A    = 16'hFF00;
      found    = 1'b0;
      guard    = 0;
      while (!found && guard < 250) begin
         tick();
         guard++;
         if (bus.Do[0] == 1'b0) found = 1'b1;
      end
      chk("a_fall_seen", {7'b0, found}, 8'h01);
      chk("a_int_before", {7'b0, int_req}, 8'h00);
      chk("a_read", bus.Do, 8'hDE);
      tick();
      chk("a_int_rise", {7'b0, int_req}, 8'h01);
      bus_idle();
      ack();
      chk("a_ack", {7'b0, int_req}, 8'h00);
      pressed = 8'h00;
      run(5 * PER);
      chk("a_release_int", {7'b0, int_req}, 8'h00);

      // Both rows; then an ack colliding with a new edge.
      write_p1(8'h00);
      pressed = 8'h18;
      run(5 * PER);
      read_chk("both_read", 8'hC6);
      ack();
      chk("both_ack", {7'b0, int_req}, 8'h00);
      pressed  = 8'h1C;
      bus.cs   = 1'b1;
      bus.rd_n = 1'b0;
      bus.A    = 16'hFF00;
      found    = 1'b0;
      guard    = 0;
      while (!found && guard < 250) begin
         tick();
         guard++;
         if (bus.Do[2] == 1'b0) found = 1'b1;
      end
      chk("up_fall_seen", {7'b0, found}, 8'h01);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk("ack_vs_edge", {7'b0, int_req}, 8'h01);
      bus_idle();
      read_chk("up_read", 8'hC2);
      ack();

      // Reset in the middle of debouncing B.
      pressed = 8'h00;
      run(5 * PER);
      ack();
      write_p1(8'h10);
      pressed = 8'h20;
      wait_btn_samples(3);
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      write_p1(8'h10);
      read_chk("b_after_reset", 8'hDF);
      wait_btn_samples(3);
      read_chk("b_after3", 8'hDF);
      wait_btn_samples(1);
      read_chk("b_after4", 8'hDD);

      // Randomized traffic against the model.
      pressed = 8'h00;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 99) < 3) pressed = pressed ^ (8'h01 << $urandom_range(0, 7));
         r = $urandom_range(0, 15);
         case (r)
            0: begin
               bus.cs = 1'b1; bus.wr_n = 1'b0; bus.A = 16'hFF00; bus.Di = 8'($urandom);
            end
            1: begin
               bus.cs = 1'b1; bus.wr_n = 1'b0; bus.A = 16'($urandom); bus.Di = 8'($urandom);
            end
            2: begin
               bus.cs = 1'b0; bus.wr_n = 1'b0; bus.A = 16'hFF00; bus.Di = 8'($urandom);
            end
            3, 4, 5, 6: begin
               bus.cs = 1'b1; bus.rd_n = 1'b0; bus.A = 16'hFF00;
            end
            7: begin
               bus.cs = 1'b1; bus.rd_n = 1'b0; bus.A = 16'($urandom);
            end
            default: bus_idle();
         endcase
         int_ack = ($urandom_range(0, 9) == 0);
         reset   = ($urandom_range(0, 999) == 0);
         tick();
         bus_idle();
         int_ack = 1'b0;
         reset   = 1'b0;
      end
      run(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
